mem_ctrl: RTL and testbench

//  Memory controller downstream of the MEM stage and the IF stage. Accepts word

---
 rtl/mem_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates MEM (load/store) and IF (fetch)
// requests onto an 8-bit synchronous RAM with one-cycle read latency.
// Optional build macro MEM_CTRL_SKIP_MASKED_EN: stores visit only enabled bytes.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_busy_o,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  input  logic              if_re_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_busy_o,
  output logic              if_done_o,
  output logic [31:0]       if_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i
);

  typedef enum logic [2:0] {StIdle, StRd, StRdLast, StWr, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              owner_if_q, owner_if_d;
  logic [23:0]       rbuf_q, rbuf_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       req_addr;
  logic              active;

  // Address bits outside the RAM window are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[31:ADDR_W], mem_addr_i[1:0],
                         if_addr_i[31:ADDR_W], if_addr_i[1:0]};

`ifdef MEM_CTRL_SKIP_MASKED_EN
  // {found, index} of the lowest set bit in a byte mask.
  function automatic logic [2:0] lowest_set(input logic [3:0] m);
    logic [2:0] r;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) r = {1'b1, 2'(k)};
    end
    return r;
  endfunction

  logic [3:0] above_mask;
  logic [2:0] first_set, next_set;

  // Mask of byte lanes strictly above the current index.
  always_comb begin
    unique case (idx_q)
      2'd0:    above_mask = 4'b1110;
      2'd1:    above_mask = 4'b1100;
      2'd2:    above_mask = 4'b1000;
      default: above_mask = 4'b0000;
    endcase
  end

  assign first_set = lowest_set(mem_sel_i);
  assign next_set  = lowest_set(sel_q & above_mask);
`endif

  assign active     = (state_q == StRd) || (state_q == StRdLast) || (state_q == StWr);
  assign mem_busy_o = active & ~owner_if_q;
  // A fetch still waiting for arbitration counts as busy, too.
  assign if_busy_o  = (active & owner_if_q) | if_re_i;
  assign mem_rdata_o = mem_rdata_q;
  assign if_rdata_o  = if_rdata_q;

  // Next-state, RAM strobes and completion pulses.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    owner_if_d  = owner_if_q;
    rbuf_d      = rbuf_q;
    mem_rdata_d = mem_rdata_q;
    if_rdata_d  = if_rdata_q;
    req_addr    = mem_addr_i;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = 8'h00;
    mem_done_o  = 1'b0;
    if_done_o   = 1'b0;

    unique case (state_q)
      StRd: begin
        ram_en_o   = 1'b1;
        ram_addr_o = base_q + ADDR_W'(idx_q);
        // Data arriving now belongs to the byte issued last cycle.
        unique case (idx_q)
          2'd1:    rbuf_d[7:0]   = ram_rdata_i;
          2'd2:    rbuf_d[15:8]  = ram_rdata_i;
          2'd3:    rbuf_d[23:16] = ram_rdata_i;
          default: ;
        endcase
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = StRdLast;
      end
      StRdLast: begin
        if (owner_if_q) if_rdata_d = {ram_rdata_i, rbuf_q};
        else            mem_rdata_d = {ram_rdata_i, rbuf_q};
        state_d = StDone;
      end
      StWr: begin
        ram_en_o    = 1'b1;
        ram_we_o    = sel_q[idx_q];
        ram_addr_o  = base_q + ADDR_W'(idx_q);
        ram_wdata_o = wdata_q[{idx_q, 3'b000} +: 8];
`ifdef MEM_CTRL_SKIP_MASKED_EN
        if (next_set[2]) idx_d = next_set[1:0];
        else             state_d = StDone;
`else
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = StDone;
`endif
      end
      StDone: begin
        if (owner_if_q) if_done_o = 1'b1;
        else            mem_done_o = 1'b1;
        state_d = StIdle;
      end
      default: ;
    endcase

    // Accept a new request when idle or finishing; MEM store > MEM load > fetch.
    if ((state_q == StIdle) || (state_q == StDone)) begin
      if (mem_we_i || mem_re_i || if_re_i) begin
        owner_if_d = ~(mem_we_i | mem_re_i);
        req_addr   = owner_if_d ? if_addr_i : mem_addr_i;
        base_d     = {req_addr[ADDR_W-1:2], 2'b00};
        sel_d      = mem_sel_i;
        wdata_d    = mem_wdata_i;
        idx_d      = 2'd0;
        if (mem_we_i) begin
`ifdef MEM_CTRL_SKIP_MASKED_EN
          if (first_set[2]) begin
            state_d = StWr;
            idx_d   = first_set[1:0];
          end else begin
            state_d = StDone;
          end
`else
          state_d = StWr;
`endif
        end else begin
          state_d = StRd;
        end
      end
    end
  end

  // State and latched request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      base_q      <= '0;
      sel_q       <= 4'h0;
      wdata_q     <= 32'h0;
      owner_if_q  <= 1'b0;
      rbuf_q      <= 24'h0;
      mem_rdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      owner_if_q  <= owner_if_d;
      rbuf_q      <= rbuf_d;
      mem_rdata_q <= mem_rdata_d;
      if_rdata_q  <= if_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random loads,
// stores and fetches against a word-level reference memory.
`timescale 1ns/1ps
module tb_mem_ctrl;
  localparam int unsigned AW     = 17;
  localparam int unsigned RAM_SZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_re, mem_we;
  logic [3:0]    mem_sel;
  logic [31:0]   mem_addr, mem_wdata;
  logic          mem_busy, mem_done;
  logic [31:0]   mem_rdata;
  logic          if_re;
  logic [31:0]   if_addr;
  logic          if_busy, if_done;
  logic [31:0]   if_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_rdata;

  int vectors = 0;
  int miscompares = 0;
  bit preload;
  logic [31:0] exp_mem_rdata, exp_if_rdata;

  logic [7:0] ram     [RAM_SZ];
  logic [7:0] ref_mem [RAM_SZ];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_re_i(mem_re), .mem_we_i(mem_we), .mem_sel_i(mem_sel),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_busy_o(mem_busy), .mem_done_o(mem_done), .mem_rdata_o(mem_rdata),
    .if_re_i(if_re), .if_addr_i(if_addr),
    .if_busy_o(if_busy), .if_done_o(if_done), .if_rdata_o(if_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h10:    return 8'h11;
      'h11:    return 8'h22;
      'h12:    return 8'h33;
      'h13:    return 8'h44;
      default: return 8'(i * 7 + (i >> 5) + 3);
    endcase
  endfunction

  // Synchronous byte RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < RAM_SZ; i++) ram[i] <= init_byte(i);
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [AW-1:0] b;
    b = {addr[AW-1:2], 2'b00};
    return {ref_mem[b + AW'(3)], ref_mem[b + AW'(2)], ref_mem[b + AW'(1)], ref_mem[b]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_busy"}, mem_busy, 0);
    check({tag, ".mem_done"}, mem_done, 0);
    check({tag, ".mem_rdata"}, mem_rdata, 0);
    check({tag, ".if_busy"}, if_busy, 0);
    check({tag, ".if_done"}, if_done, 0);
    check({tag, ".if_rdata"}, if_rdata, 0);
    check({tag, ".ram_en"}, ram_en, 0);
    check({tag, ".ram_we"}, ram_we, 0);
    check({tag, ".ram_addr"}, ram_addr, 0);
    check({tag, ".ram_wdata"}, ram_wdata, 0);
  endtask

  // kind: 0 = MEM load, 1 = MEM store, 2 = fetch. Controller must be idle.
  task automatic run_op(input int kind, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata);
    logic [AW-1:0] base;
    logic [AW-1:0] ea[$];
    logic          ew[$];
    logic [7:0]    ed[$];
    int lat;
    base = {addr[AW-1:2], 2'b00};
    for (int k = 0; k < 4; k++) begin
      if (kind == 1) begin
`ifdef MEM_CTRL_SKIP_MASKED_EN
        if (!sel[k]) continue;
`endif
        ea.push_back(base + AW'(k));
        ew.push_back(sel[k]);
        ed.push_back(wdata[8*k +: 8]);
      end else begin
        ea.push_back(base + AW'(k));
        ew.push_back(1'b0);
        ed.push_back(8'h00);
      end
    end
    if (kind == 1) begin
      lat = ea.size() + 1;
      for (int k = 0; k < 4; k++) if (sel[k]) ref_mem[base + AW'(k)] = wdata[8*k +: 8];
    end else begin
      lat = 6;
      if (kind == 2) exp_if_rdata = ref_word(addr);
      else           exp_mem_rdata = ref_word(addr);
    end

    mem_we = (kind == 1); mem_re = (kind == 0); if_re = (kind == 2);
    mem_addr = addr; if_addr = addr; mem_sel = sel; mem_wdata = wdata;
    tick();
    mem_we = 0; mem_re = 0; if_re = 0;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      check("ram_en", ram_en, (cyc <= ea.size()));
      if (ram_en && cyc <= ea.size()) begin
        check("ram_addr", ram_addr, ea[cyc-1]);
        check("ram_we", ram_we, ew[cyc-1]);
        if (kind == 1) check("ram_wdata", ram_wdata, ed[cyc-1]);
      end
      if (kind == 2) begin
        check("if_busy", if_busy, (cyc < lat));
        check("if_done", if_done, (cyc == lat));
        check("mem_busy_idle", mem_busy, 0);
        check("mem_done_idle", mem_done, 0);
      end else begin
        check("mem_busy", mem_busy, (cyc < lat));
        check("mem_done", mem_done, (cyc == lat));
        check("if_busy_idle", if_busy, 0);
        check("if_done_idle", if_done, 0);
      end
      if (cyc == lat) begin
        check("mem_rdata", mem_rdata, exp_mem_rdata);
        check("if_rdata", if_rdata, exp_if_rdata);
      end
      tick();
    end
    check("done_pulse_once", mem_done | if_done, 0);
    check("idle_ram_en", ram_en, 0);
    check("rdata_held", mem_rdata, exp_mem_rdata);
  endtask

  initial begin
    logic [31:0] w;
    int bad;
    rst = 1; preload = 1;
    mem_re = 0; mem_we = 0; mem_sel = 0; mem_addr = 0; mem_wdata = 0;
    if_re = 0; if_addr = 0;
    exp_mem_rdata = 0; exp_if_rdata = 0;
    for (int i = 0; i < RAM_SZ; i++) ref_mem[i] = init_byte(i);
    tick();
    preload = 0;
    tick();
    check_all_zero("reset");
    rst = 0;

    // Load at 0x10.
    run_op(0, 4'hF, 32'h10, 32'h0);
    check("lw_0x10_word", mem_rdata, 32'h4433_2211);

    // Single-byte store.
    run_op(1, 4'b0100, 32'h20, 32'hAAAA_AAAA);
    check("sb_byte2", ram[17'h22], 8'hAA);
    for (int k = 0; k < 4; k++) check("sb_ram", ram[17'h20 + 17'(k)], ref_mem[17'h20 + 17'(k)]);

    // Concurrent MEM load and fetch: MEM first, fetch accepted in MEM's DONE.
    exp_mem_rdata = ref_word(32'h40);
    exp_if_rdata  = ref_word(32'h80);
    mem_re = 1; if_re = 1; mem_addr = 32'h40; if_addr = 32'h80;
    tick();
    mem_re = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      check("arb_if_busy", if_busy, 1);
      check("arb_mem_done", mem_done, (c == 6));
      check("arb_if_done_early", if_done, 0);
    end
    check("arb_mem_rdata", mem_rdata, exp_mem_rdata);
    tick();
    if_re = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      check("arb_fetch_busy", if_busy, (c < 6));
      check("arb_fetch_done", if_done, (c == 6));
      check("arb_mem_busy", mem_busy, 0);
      if (c == 1) check("arb_fetch_addr", ram_addr, 32'h80);
    end
    check("arb_if_rdata", if_rdata, exp_if_rdata);
    tick();

    // Reset in cycle 3 of a load.
    mem_re = 1; mem_addr = 32'h44;
    tick();
    mem_re = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    check_all_zero("midreset");
    exp_mem_rdata = 0; exp_if_rdata = 0;
    for (int c = 0; c < 8; c++) begin
      check("midreset_no_done", mem_done, 0);
      check("midreset_no_en", ram_en, 0);
      tick();
    end
    run_op(0, 4'hF, 32'h44, 32'h0);

    // Back-to-back store then load at the same address.
    w = $urandom();
    for (int k = 0; k < 4; k++) ref_mem[17'h100 + 17'(k)] = w[8*k +: 8];
    mem_we = 1; mem_sel = 4'hF; mem_addr = 32'h100; mem_wdata = w;
    tick();
    mem_we = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) tick();
      check("b2b_sw_done", mem_done, (c == 5));
    end
    mem_re = 1;
    tick();
    mem_re = 0;
    check("b2b_lw_accept_en", ram_en, 1);
    check("b2b_lw_accept_addr", ram_addr, 32'h100);
    check("b2b_lw_busy", mem_busy, 1);
    for (int c = 2; c <= 6; c++) begin
      tick();
      check("b2b_lw_done", mem_done, (c == 6));
    end
    check("b2b_lw_rdata", mem_rdata, w);
    exp_mem_rdata = w;
    tick();

    // Top of the RAM window: no wrap into address 0.
    run_op(1, 4'hF, 32'h0001_FFFC, $urandom());
    check("top_no_wrap_ram0", ram[0], ref_mem[0]);
    run_op(0, 4'hF, 32'h0001_FFFC, 32'h0);
    run_op(2, 4'hF, 32'hABCE_FFFC, 32'h0);

    // Random mix of loads, stores and fetches.
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 2));
      a = ($urandom() & 32'hFFFE_0000) | ($urandom_range(0, 63) << 2);
      run_op(kind, 4'($urandom_range(0, 15)), a, $urandom());
    end
    bad = 0;
    for (int i = 0; i < 'h200; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("ram_contents_mismatches", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
